// File: rtl/usb_rx_byte_fifo.sv
// Elastic byte FIFO between the USB CDC core's OUT stream and the application.
// First-word-fall-through head, registered level counter, synchronous flush.
module usb_rx_byte_fifo #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       clr_i,
  input  logic [WIDTH-1:0]           in_data_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [WIDTH-1:0]           out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       almost_full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wp_q, wp_d;
  logic [PtrW-1:0]  rp_q, rp_d;
  logic [LvlW-1:0]  level_q, level_d;

  logic wr_fire;
  logic rd_fire;

  // Flags decode from the registered level only, so in_ready_o never depends on out_ready_i.
  always_comb begin
    in_ready_o    = (level_q != LvlW'(DEPTH));
    out_valid_o   = (level_q != '0);
    almost_full_o = (level_q >= LvlW'(AFULL_LEVEL));
    level_o       = level_q;
    out_data_o    = out_valid_o ? mem_q[rp_q] : '0;
    wr_fire       = in_valid_i & in_ready_o;
    rd_fire       = out_valid_o & out_ready_i;
  end

  // Next-state: flush wins over any handshake; otherwise pointers and level track the fires.
  always_comb begin
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    if (clr_i) begin
      // Storage is intentionally left untouched; only the bookkeeping is reset.
      wp_d    = '0;
      rp_d    = '0;
      level_d = '0;
    end else begin
      if (wr_fire) begin
        mem_d[wp_q] = in_data_i;
        wp_d        = wp_q + PtrW'(1);
      end
      if (rd_fire) begin
        rp_d = rp_q + PtrW'(1);
      end
      if (wr_fire && !rd_fire) begin
        level_d = level_q + LvlW'(1);
      end else if (rd_fire && !wr_fire) begin
        level_d = level_q - LvlW'(1);
      end
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
    end
  end

  // Storage array, cleared on reset so out_data_o never shows stale or unknown bytes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule
